fifo: RTL and testbench
=======================

# fifo

Synchronous first-in/first-out buffer, 16 entries of 20 bits by default, with full/empty status and an error flag for illegal accesses. It decouples a producer and a consumer that share one clock, such as instruction/event queues inside the Chip8 core. Storage is register- or RAM-based. The read data output is registered.

## Interface
Parameters:
- `WIDTH`, 20: data word width in bits.
- `DEPTH`, 16: number of entries. Must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `read`, input, 1: pop request, sampled at the rising edge.
- `write`, input, 1: push request, sampled at the rising edge.
- `in`, input, `WIDTH`: data pushed when `write` is accepted.
- `out`, output, `WIDTH`: registered read data. Holds its value between pops.
- `empty`, output, 1: count == 0.
- `full`, output, 1: count == `DEPTH`.
- `ERR`, output, 1: one-cycle pulse flagging an overflow or underflow attempt.

## Operation
- State:
  - write pointer `wp`, log2(`DEPTH`) bits.
  - read pointer `rp`, log2(`DEPTH`) bits.
  - `count`, log2(`DEPTH`)+1 bits.
  - storage array, `DEPTH` × `WIDTH`.
- Pointers wrap modulo `DEPTH` with no special handling.
- Write accepted when `write` and (!`full` or `read`):
  - mem[`wp`] <= `in`
  - `wp` <= `wp`+1
- Read accepted when `read` and !`empty`:
  - `out` <= mem[`rp`]
  - `rp` <= `rp`+1
- Count update: `count` += (write accepted) − (read accepted).
- Overflow, i.e. `write` while `full` without `read`: the write is dropped, memory and `wp` are unchanged, and `ERR` pulses.
- Underflow, i.e. `read` while `empty`: the read is dropped, `out` and `rp` are unchanged, and `ERR` pulses. A simultaneous write is still accepted.
- Simultaneous read and write, non-empty: both are performed and `count` is unchanged. When `full`, both are performed and `full` stays asserted.
- `empty` and `full` are combinational decodes of `count`.
- Data order is strictly FIFO. The array is never reset, only the pointers and `count`.
- Reset values:
  - `wp`=0, `rp`=0, `count`=0
  - `out`=0
  - `ERR`=0
  - hence `empty`=1, `full`=0
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Write latency: data written at edge N is readable by a `read` at edge N+1 or later. `empty` deasserts after edge N.
- Read latency: `out` shows the popped word immediately after the edge that accepts the read, i.e. one cycle.
- `full`/`empty` change after the edge that changes `count`. There are no look-ahead flags.
- `ERR` is registered: high for exactly the one cycle following the offending edge. Consecutive illegal requests keep it high.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- Shared package `fifo_pkg`:
  - default `WIDTH`/`DEPTH` constants
  - a `fifo_data_t` typedef of `WIDTH` bits
- One natural sub-module, `fifo_ram`: a simple dual-port array with one synchronous write port and one synchronous read port into a register.
- Pointer, count, flag and error logic stay in the top level.

## Test plan
- Reset state: assert `rst` asynchronously mid-clock.
  - Expect `empty`=1, `full`=0, `ERR`=0, `out`=0 at once, without waiting for an edge.
- Basic order:
  - Write 1..15, one per pulse. Expect `empty`=0 after the first write and `full`=0 throughout.
  - Read 12. Expect `out` = 1..12 in order and 3 entries left.
- Wrap-around:
  - Write 16..19 on top of the 3 entries left above.
  - Read 7. Expect `out` = 13..19, `empty`=1 after the 7th read, and `ERR` never asserted.
- Fill to full:
  - Hold `write` for 16 consecutive cycles with `in` incrementing 20..35. Expect `full`=1 after the 16th edge.
  - A 17th write attempt drops the word, pulses `ERR` for one cycle, and leaves the contents unchanged.
- Drain:
  - Hold `read` for 16 cycles. Expect `out` = 20..35 back-to-back and `empty`=1 after the last read.
  - A further read pulses `ERR` and leaves `out` = 35.
- Simultaneous access:
  - With 1 entry stored, assert `read`+`write` for 4 cycles. Expect `count` to stay at 1, order preserved, and no `ERR`.
  - When `full`, `read`+`write` keeps `full`=1 with no `ERR`.
  - When `empty`, `read`+`write` stores the word and pulses `ERR`.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
package fifo_pkg;
  localparam int FIFO_WIDTH = 20;
  localparam int FIFO_DEPTH = 16;

  typedef logic [FIFO_WIDTH-1:0] fifo_data_t;
endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array has no reset so it can map onto RAM; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO with full/empty decode and a registered overflow/underflow pulse.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic             full,
  output logic             ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          wr_ok, rd_ok, err_q;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop in the same cycle frees a slot, so a write while full is still legal.
  assign wr_ok = write & (~full | read);
  assign rd_ok = read & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      err_q <= (write & full & ~read) | (read & empty);
    end
  end

  assign ERR = err_q;

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wp),
    .wdata (in),
    .re    (rd_ok),
    .raddr (rp),
    .rdata (out)
  );

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: queue-based reference model checked every cycle, plus literal pins.
module tb_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read = 1'b0, write = 1'b0;
  fifo_data_t in = '0;
  fifo_data_t out;
  logic       empty, full, ERR;

  int passed = 0, total = 0;
  bit chk_en = 1'b0;

  fifo dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .in(in),
    .out(out), .empty(empty), .full(full), .ERR(ERR)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored words.
  fifo_data_t q[$];
  fifo_data_t m_out;
  logic       m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_out = '0;
      m_err = 1'b0;
    end else begin
      automatic int  n  = q.size();
      automatic bit  rd = read && n > 0;
      automatic bit  wr = write && (n < FIFO_DEPTH || read);
      m_err = (write && n == FIFO_DEPTH && !read) || (read && n == 0);
      if (rd) m_out = q.pop_front();
      if (wr) q.push_back(in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("out",   32'(out),   32'(m_out));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full",  32'(full),  32'(q.size() == FIFO_DEPTH));
      chk("ERR",   32'(ERR),   32'(m_err));
    end
  end

  // One clock: drive on the falling edge, return just after the rising edge.
  task automatic step(input bit r, input bit w, input int d);
    @(negedge clk);
    read = r; write = w; in = fifo_data_t'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0);
  endtask

  initial begin
    #12 rst = 1'b0;
    chk_en = 1'b1;

    // Put state in the design, provoke ERR, then reset asynchronously mid-cycle.
    step(0, 1, 7); step(0, 1, 8); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    chk("pre_rst_err", 32'(ERR), 32'd1);
    chk("pre_rst_out", 32'(out), 32'd8);
    #1 rst = 1'b1;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_err",   32'(ERR),   32'd0);
    chk("rst_out",   32'(out),   32'd0);
    @(negedge clk);
    rst = 1'b0; read = 1'b0; write = 1'b0;

    // Basic order.
    for (int i = 1; i <= 15; i++) begin
      step(0, 1, i);
      if (i == 1) chk("first_write_empty", 32'(empty), 32'd0);
    end
    chk("fifteen_full", 32'(full), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0);
      chk("order_out", 32'(out), 32'(i));
    end
    chk("left_three", 32'(q.size()), 32'd3);

    // Wrap-around.
    for (int i = 16; i <= 19; i++) step(0, 1, i);
    for (int i = 13; i <= 19; i++) begin
      step(1, 0, 0);
      chk("wrap_out", 32'(out), 32'(i));
      chk("wrap_err", 32'(ERR), 32'd0);
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Fill, then overflow.
    for (int i = 20; i <= 35; i++) step(0, 1, i);
    chk("fill_full", 32'(full), 32'd1);
    step(0, 1, 99);
    chk("ovf_err", 32'(ERR), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);
    idle();
    chk("ovf_err_clear", 32'(ERR), 32'd0);

    // Drain, then underflow.
    for (int i = 20; i <= 35; i++) begin
      step(1, 0, 0);
      chk("drain_out", 32'(out), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1, 0, 0);
    chk("udf_err", 32'(ERR), 32'd1);
    chk("udf_out", 32'(out), 32'd35);
    idle();

    // Simultaneous with one entry held.
    step(0, 1, 100);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 101 + i);
      chk("rw_out", 32'(out), 32'(100 + i));
      chk("rw_err", 32'(ERR), 32'd0);
      chk("rw_empty", 32'(empty), 32'd0);
    end
    step(1, 0, 0);
    chk("rw_last", 32'(out), 32'd104);
    chk("rw_last_empty", 32'(empty), 32'd1);

    // Simultaneous while full.
    for (int i = 200; i <= 215; i++) step(0, 1, i);
    step(1, 1, 216);
    chk("rwfull_full", 32'(full), 32'd1);
    chk("rwfull_err",  32'(ERR),  32'd0);
    chk("rwfull_out",  32'(out),  32'd200);
    for (int i = 201; i <= 216; i++) step(1, 0, 0);
    chk("rwfull_tail", 32'(out), 32'd216);

    // Simultaneous while empty: write lands, read flags ERR.
    step(1, 1, 300);
    chk("rwempty_err",   32'(ERR),   32'd1);
    chk("rwempty_empty", 32'(empty), 32'd0);
    chk("rwempty_out",   32'(out),   32'd216);
    step(1, 0, 0);
    chk("rwempty_pop", 32'(out), 32'd300);
    idle(); idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
